// File: rtl/satd_control.sv
// Sequencer for the SATD Hadamard datapath: a row pass, then a column pass, then a done pulse.
// All outputs decode directly from flops, so there is no input-to-output combinational path.
module satd_control #(
    parameter int unsigned N          = 4,
    parameter int unsigned CNT_W      = $clog2(N),
    parameter bit          AUTO_START = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             en,
    output logic             stage,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StRow, StCol, StDone} state_e;

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             go;

    assign go = start | AUTO_START;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    count_d = '0;
                    if (go) state_d = StRow;
                end
                StRow: begin
                    if (count_q == LastIdx) begin
                        state_d = StCol;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                StCol: begin
                    if (count_q == LastIdx) begin
                        state_d = StDone;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    // Back-to-back blocks skip IDLE entirely.
                    count_d = '0;
                    state_d = go ? StRow : StIdle;
                end
                default: begin
                    state_d = StIdle;
                    count_d = '0;
                end
            endcase
        end
    end

    assign stage = (state_q == StCol);
    assign busy  = (state_q == StRow) || (state_q == StCol);
    assign done  = (state_q == StDone);
    assign count = count_q;

endmodule

// File: tb/tb_satd_control.sv
// Randomized bench for satd_control: a manual-start instance and a free-running instance,
// both checked each cycle against a position-in-block reference model.
module tb_satd_control;

    localparam int N     = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             en = 1'b0;
    logic             stage_m, busy_m, done_m;
    logic [CNT_W-1:0] count_m;
    logic             stage_a, busy_a, done_a;
    logic [CNT_W-1:0] count_a;

    int checks = 0;
    int failures = 0;
    // Model position: -1 idle, 0..2N-1 row then column passes, 2N done.
    int pos_m = -1;
    int pos_a = -1;
    int done_seen = 0;

    always #5 clk = ~clk;

    satd_control #(.N(N), .CNT_W(CNT_W), .AUTO_START(1'b0)) u_dut_man (
        .clk(clk), .reset(reset), .start(start), .en(en),
        .stage(stage_m), .count(count_m), .busy(busy_m), .done(done_m)
    );

    satd_control #(.N(N), .CNT_W(CNT_W), .AUTO_START(1'b1)) u_dut_auto (
        .clk(clk), .reset(reset), .start(1'b0), .en(en),
        .stage(stage_a), .count(count_a), .busy(busy_a), .done(done_a)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int next_pos(input int pos, input bit go, input bit adv);
        if (!adv) return pos;
        if (pos < 0 || pos == 2 * N) return go ? 0 : -1;
        return pos + 1;
    endfunction

    task automatic check_dut(input string tag, input int pos, input logic st, input int cnt,
                             input logic bsy, input logic dn);
        bit seq;
        seq = (pos >= 0) && (pos < 2 * N);
        check({tag, ".stage"}, int'(st), int'(seq && pos >= N));
        check({tag, ".count"}, cnt, seq ? pos % N : 0);
        check({tag, ".busy"}, int'(bsy), int'(seq));
        check({tag, ".done"}, int'(dn), int'(pos == 2 * N));
    endtask

    task automatic check_all(input string tag);
        check_dut({tag, ".man"}, pos_m, stage_m, int'(count_m), busy_m, done_m);
        check_dut({tag, ".auto"}, pos_a, stage_a, int'(count_a), busy_a, done_a);
    endtask

    // Called at a falling edge; applies inputs, takes one rising edge, checks, returns at falling edge.
    task automatic step(input logic s, input logic e, input string tag);
        start = s;
        en = e;
        @(posedge clk);
        if (reset) begin
            pos_m = next_pos(pos_m, s, e);
            pos_a = next_pos(pos_a, 1'b1, e);
        end
        #1;
        check_all(tag);
        if (done_m) done_seen++;
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        pos_m = -1;
        pos_a = -1;
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int guard;
        int d0;
        #3;
        check_all("rst_low");
        @(posedge clk);
        #1;
        check_all("rst_low_edge");
        @(negedge clk);
        reset = 1'b1;

        // Single start pulse: full block, done exactly once, then idle.
        d0 = done_seen;
        step(1'b1, 1'b1, "single");
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, "single");
        check("single.done_count", done_seen - d0, 1);

        // Stall in ROW at count 2 for two cycles.
        step(1'b1, 1'b1, "stall");
        step(1'b0, 1'b1, "stall");
        step(1'b0, 1'b1, "stall");
        check("stall.at_cnt2", int'(count_m), 2);
        step(1'b1, 1'b0, "stall_frz");
        step(1'b0, 1'b0, "stall_frz");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, "stall");

        // Start held high: back-to-back blocks.
        d0 = done_seen;
        for (int i = 0; i < 27; i++) step(1'b1, 1'b1, "held");
        check("held.done_count", done_seen - d0, 3);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, "held_tail");

        // Reset during COL count 1.
        step(1'b1, 1'b1, "abort");
        guard = 0;
        while (pos_m != N + 1 && guard < 20) begin
            step(1'b0, 1'b1, "abort");
            guard++;
        end
        check("abort.reached_col1", int'(stage_m && count_m == 1), 1);
        d0 = done_seen;
        async_reset("abort");
        check("abort.no_done", done_seen - d0, 0);
        step(1'b1, 1'b1, "rerun");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, "rerun");

        // Random traffic with occasional stalls and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) async_reset("rand");
            else step(($urandom_range(9) < 3), ($urandom_range(9) < 8), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
